// File: rtl/pmt_trig_pkg.sv
// Shared types and helpers for the multi-channel PMT phase trigger.
// Holds the channel FSM state encoding and half-bin range helpers.
package pmt_trig_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FIRE,
        DEAD
    } state_t;

    localparam int H1_LO = 0;

    function automatic int h2_lo(input int ns);
        return ns / 2;
    endfunction

    function automatic int popcount(input logic [31:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/pmt_chan_fsm.sv
// Per-channel fire/dead-time sequencer.
// A trigger opens FIRE for firingticks cycles, then DEAD for deadticks cycles.
module pmt_chan_fsm
    import pmt_trig_pkg::*;
#(
    parameter int DTW = 8
) (
    input  logic           clkin,
    input  logic           nrst,
    input  logic           clear,
    input  logic           trig,
    input  logic [DTW-1:0] firingticks,
    input  logic [DTW-1:0] deadticks,
    output logic           fire
);

    state_t         state;
    logic [DTW-1:0] cnt;

    always_ff @(posedge clkin or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
            cnt   <= '0;
            fire  <= 1'b0;
        end else if (clear) begin
            state <= IDLE;
            cnt   <= '0;
            fire  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (trig) begin
                        state <= FIRE;
                        fire  <= 1'b1;
                        cnt   <= (firingticks == '0) ? '0
                               : firingticks - DTW'(1);
                    end
                end
                FIRE: begin
                    if (cnt == '0) begin
                        fire <= 1'b0;
                        if (deadticks == '0) begin
                            state <= IDLE;
                        end else begin
                            state <= DEAD;
                            cnt   <= deadticks - DTW'(1);
                        end
                    end else begin
                        cnt <= cnt - DTW'(1);
                    end
                end
                DEAD: begin
                    // a trigger arriving on the DEAD->IDLE cycle is dropped
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - DTW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    fire  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pmt_phase_trigger.sv
// Multi-channel LVDS phase trigger: edge veto, word-straddling phase
// alignment, early/late halves, fire/dead FSMs, multiplicity, histograms.
module pmt_phase_trigger
    import pmt_trig_pkg::*;
#(
    parameter int NCH = 4,
    parameter int NS  = 4,
    parameter int HW  = 32,
    parameter int DTW = 8
) (
    input  logic                     clkin,
    input  logic                     nrst,
    input  logic [NCH*NS-1:0]        lvds_rx,
    input  logic [$clog2(NS)-1:0]    phaseoffset,
    input  logic                     usefullwidth,
    input  logic                     vetopmtlast,
    input  logic                     passthrough,
    input  logic [DTW-1:0]           firingticks,
    input  logic [DTW-1:0]           deadticks,
    input  logic                     resethist,
    input  logic [$clog2(NCH)-1:0]   hist_ch,
    input  logic [$clog2(NS)-1:0]    hist_bin,
    output logic [HW-1:0]            hist_data,
    output logic [NCH-1:0]           out1,
    output logic [NCH-1:0]           out2,
    output logic [NCH-1:0]           fire,
    output logic [$clog2(NCH+1)-1:0] mult
);

    localparam int MW = $clog2(NCH + 1);
    localparam int IW = $clog2(NCH * NS);
    localparam int HL = h2_lo(NS);

    logic [NCH*NS-1:0] r0, r1, av;
    logic [NCH-1:0]    m2, h1, h2, trig_q;
    logic              rs1, rs2;
    logic [HW-1:0]     hist [NCH*NS];
    logic [IW-1:0]     rd_idx;

    always_ff @(posedge clkin or negedge nrst) begin
        if (!nrst) begin
            r0 <= '0;
            r1 <= '0;
            m2 <= '0;
        end else begin
            r0 <= lvds_rx;
            r1 <= r0;
            for (int c = 0; c < NCH; c++) begin
                m2[c] <= r1[c*NS+NS-1];
            end
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [NS-1:0]   w0, w1, e0, e1, al;
        logic [2*NS-1:0] ext;
        logic            rest1, rest2;

        assign w0  = r0[c*NS +: NS];
        assign w1  = r1[c*NS +: NS];
        assign e1  = vetopmtlast ? (w1 & ~{w1[NS-2:0], m2[c]}) : w1;
        assign e0  = vetopmtlast ? (w0 & ~{w0[NS-2:0], w1[NS-1]}) : w0;
        // upper word supplies bins that rotate past the word boundary
        assign ext = {e0, e1};
        assign al  = ext[phaseoffset +: NS];

        always_comb begin
            rest1 = 1'b0;
            rest2 = 1'b0;
            for (int k = H1_LO + 1; k < HL; k++) begin
                rest1 |= al[k];
            end
            for (int k = HL + 1; k < NS; k++) begin
                rest2 |= al[k];
            end
        end

        assign h1[c] = al[H1_LO] | (usefullwidth & rest1);
        assign h2[c] = al[HL] | (usefullwidth & rest2);
        assign av[c*NS +: NS] = al;

        pmt_chan_fsm #(.DTW(DTW)) u_fsm (
            .clkin       (clkin),
            .nrst        (nrst),
            .clear       (passthrough),
            .trig        (trig_q[c]),
            .firingticks (firingticks),
            .deadticks   (deadticks),
            .fire        (fire[c])
        );
    end

    always_ff @(posedge clkin or negedge nrst) begin
        if (!nrst) begin
            out1   <= '0;
            out2   <= '0;
            mult   <= '0;
            trig_q <= '0;
        end else if (passthrough) begin
            for (int c = 0; c < NCH; c++) begin
                out1[c] <= |r0[c*NS +: NS];
            end
            out2   <= '0;
            mult   <= '0;
            trig_q <= '0;
        end else begin
            out1   <= h1;
            out2   <= h2;
            mult   <= MW'(popcount(32'(h1 | h2)));
            trig_q <= h1 | h2;
        end
    end

    always_ff @(posedge clkin or negedge nrst) begin
        if (!nrst) begin
            rs1 <= 1'b0;
            rs2 <= 1'b0;
        end else begin
            rs1 <= resethist;
            rs2 <= rs1;
        end
    end

    always_ff @(posedge clkin or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < NCH*NS; i++) begin
                hist[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH*NS; i++) begin
                if (rs2) begin
                    hist[i] <= '0;
                end else if (!passthrough && av[i] && hist[i] != '1) begin
                    hist[i] <= hist[i] + HW'(1);
                end
            end
        end
    end

    assign rd_idx = IW'(int'(hist_ch) * NS + int'(hist_bin));

    always_ff @(posedge clkin or negedge nrst) begin
        if (!nrst) begin
            hist_data <= '0;
        end else if (int'(hist_ch) < NCH) begin
            hist_data <= hist[rd_idx];
        end else begin
            hist_data <= '0;
        end
    end

endmodule

// File: tb/tb_pmt_phase_trigger.sv
// Directed testbench for pmt_phase_trigger (NCH=4, NS=4, HW=4).
// Each task drives one scenario and checks against hand-derived values.
module tb_pmt_phase_trigger;

    localparam int NCH = 4;
    localparam int NS  = 4;
    localparam int HW  = 4;
    localparam int DTW = 8;

    logic              clkin;
    logic              nrst;
    logic [NCH*NS-1:0] lvds_rx;
    logic [1:0]        phaseoffset;
    logic              usefullwidth;
    logic              vetopmtlast;
    logic              passthrough;
    logic [DTW-1:0]    firingticks;
    logic [DTW-1:0]    deadticks;
    logic              resethist;
    logic [1:0]        hist_ch;
    logic [1:0]        hist_bin;
    logic [HW-1:0]     hist_data;
    logic [NCH-1:0]    out1;
    logic [NCH-1:0]    out2;
    logic [NCH-1:0]    fire;
    logic [2:0]        mult;

    int checks = 0;
    int errors = 0;

    pmt_phase_trigger #(
        .NCH(NCH), .NS(NS), .HW(HW), .DTW(DTW)
    ) dut (
        .clkin        (clkin),
        .nrst         (nrst),
        .lvds_rx      (lvds_rx),
        .phaseoffset  (phaseoffset),
        .usefullwidth (usefullwidth),
        .vetopmtlast  (vetopmtlast),
        .passthrough  (passthrough),
        .firingticks  (firingticks),
        .deadticks    (deadticks),
        .resethist    (resethist),
        .hist_ch      (hist_ch),
        .hist_bin     (hist_bin),
        .hist_data    (hist_data),
        .out1         (out1),
        .out2         (out2),
        .fire         (fire),
        .mult         (mult)
    );

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic read_hist(input int ch, input int bin,
                             output logic [HW-1:0] v);
        hist_ch  = 2'(ch);
        hist_bin = 2'(bin);
        tick();
        v = hist_data;
    endtask

    task automatic clear_hist();
        lvds_rx = '0;
        ticks(3);
        resethist = 1'b1;
        tick();
        resethist = 1'b0;
        ticks(4);
    endtask

    task automatic test_reset();
        logic [HW-1:0] v;
        nrst = 1'b0;
        ticks(2);
        checks++;
        if ({out1, out2, fire, mult} !== '0) begin
            errors++;
            $display("FAIL reset_outs: got %h/%h/%h/%h want 0",
                     out1, out2, fire, mult);
        end
        checks++;
        if (hist_data !== '0) begin
            errors++;
            $display("FAIL reset_hist_data: got %0d want 0", hist_data);
        end
        nrst = 1'b1;
        tick();
        read_hist(2, 3, v);
        checks++;
        if (v !== '0) begin
            errors++;
            $display("FAIL reset_hist23: got %0d want 0", v);
        end
    endtask

    task automatic test_single_bin();
        logic [HW-1:0] v;
        clear_hist();
        lvds_rx = 16'h0001;
        tick();
        lvds_rx = '0;
        ticks(2);
        checks++;
        if (out1 !== 4'b0001 || out2 !== 4'b0000) begin
            errors++;
            $display("FAIL single_out: got %b/%b want 0001/0000", out1, out2);
        end
        tick();
        checks++;
        if (out1 !== 4'b0000) begin
            errors++;
            $display("FAIL single_pulse_len: got %b want 0000", out1);
        end
        read_hist(0, 0, v);
        checks++;
        if (v !== 4'd1) begin
            errors++;
            $display("FAIL single_hist00: got %0d want 1", v);
        end
        read_hist(0, 1, v);
        checks++;
        if (v !== 4'd0) begin
            errors++;
            $display("FAIL single_hist01: got %0d want 0", v);
        end
    endtask

    task automatic test_straddle();
        logic [HW-1:0] v;
        clear_hist();
        phaseoffset  = 2'd3;
        usefullwidth = 1'b1;
        lvds_rx = 16'h0010;
        tick();
        lvds_rx = '0;
        tick();
        checks++;
        if (out1 !== 4'b0010 || out2 !== 4'b0000) begin
            errors++;
            $display("FAIL straddle_out: got %b/%b want 0010/0000", out1, out2);
        end
        tick();
        checks++;
        if (out1 !== 4'b0000) begin
            errors++;
            $display("FAIL straddle_pulse_len: got %b want 0000", out1);
        end
        ticks(2);
        for (int k = 0; k < NS; k++) begin
            read_hist(1, k, v);
            checks++;
            if (v !== ((k == 1) ? 4'd1 : 4'd0)) begin
                errors++;
                $display("FAIL straddle_hist1%0d: got %0d want %0d",
                         k, v, (k == 1) ? 1 : 0);
            end
        end
        phaseoffset  = 2'd0;
        usefullwidth = 1'b0;
    endtask

    task automatic test_veto();
        logic [HW-1:0] v;
        int n1, n2;
        clear_hist();
        vetopmtlast = 1'b1;
        n1 = 0;
        n2 = 0;
        for (int i = 0; i < 10; i++) begin
            lvds_rx = (i < 5) ? 16'h0F00 : 16'h0000;
            tick();
            n1 += int'(out1[2]);
            n2 += int'(out2[2]);
        end
        checks++;
        if (n1 != 1 || n2 != 0) begin
            errors++;
            $display("FAIL veto_pulses: got %0d/%0d want 1/0", n1, n2);
        end
        read_hist(2, 0, v);
        checks++;
        if (v !== 4'd1) begin
            errors++;
            $display("FAIL veto_hist20: got %0d want 1", v);
        end
        read_hist(2, 3, v);
        checks++;
        if (v !== 4'd0) begin
            errors++;
            $display("FAIL veto_hist23: got %0d want 0", v);
        end
        vetopmtlast = 1'b0;
        clear_hist();
        lvds_rx = 16'h0F00;
        ticks(5);
        lvds_rx = '0;
        ticks(4);
        for (int k = 0; k < NS; k++) begin
            read_hist(2, k, v);
            checks++;
            if (v !== 4'd5) begin
                errors++;
                $display("FAIL noveto_hist2%0d: got %0d want 5", k, v);
            end
        end
    endtask

    task automatic test_dead_time();
        logic [13:0] fh;
        firingticks = 8'd3;
        deadticks   = 8'd2;
        lvds_rx = '0;
        ticks(6);
        fh = '0;
        for (int i = 0; i < 14; i++) begin
            lvds_rx = (i <= 6 && (i % 2) == 0) ? 16'h1000 : 16'h0000;
            tick();
            fh[i] = fire[3];
        end
        checks++;
        if (fh !== 14'h0E38) begin
            errors++;
            $display("FAIL dead_fire_trace: got %b want %b", fh, 14'h0E38);
        end
        checks++;
        if (fire[2:0] !== 3'b000) begin
            errors++;
            $display("FAIL dead_other_fire: got %b want 000", fire[2:0]);
        end
        firingticks = 8'd1;
        deadticks   = 8'd0;
        ticks(8);
    endtask

    task automatic test_passthrough();
        logic [HW-1:0] v;
        clear_hist();
        passthrough = 1'b1;
        lvds_rx = 16'h0004;
        tick();
        lvds_rx = '0;
        tick();
        checks++;
        if (out1 !== 4'b0001 || out2 !== 4'b0000 || mult !== 3'd0) begin
            errors++;
            $display("FAIL pass_out: got %b/%b/%0d want 0001/0000/0",
                     out1, out2, mult);
        end
        tick();
        checks++;
        if (out1 !== 4'b0000) begin
            errors++;
            $display("FAIL pass_pulse_len: got %b want 0000", out1);
        end
        ticks(3);
        checks++;
        if (fire !== 4'b0000) begin
            errors++;
            $display("FAIL pass_fire: got %b want 0000", fire);
        end
        passthrough = 1'b0;
        read_hist(0, 2, v);
        checks++;
        if (v !== 4'd0) begin
            errors++;
            $display("FAIL pass_hist02: got %0d want 0", v);
        end
    endtask

    task automatic test_saturate();
        logic [HW-1:0] v;
        bit ok;
        clear_hist();
        lvds_rx = 16'h0001;
        ticks(20);
        lvds_rx = '0;
        ticks(4);
        read_hist(0, 0, v);
        checks++;
        if (v !== 4'd15) begin
            errors++;
            $display("FAIL sat_hist00: got %0d want 15", v);
        end
        resethist = 1'b1;
        tick();
        resethist = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (hist_data === 4'd0) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL sat_clear: got %0d want 0 within 4", hist_data);
        end
    endtask

    task automatic test_mult_reset();
        logic [HW-1:0] v;
        firingticks = 8'd5;
        deadticks   = 8'd0;
        lvds_rx = 16'h1111;
        tick();
        lvds_rx = '0;
        ticks(2);
        checks++;
        if (mult !== 3'd4 || out1 !== 4'hF) begin
            errors++;
            $display("FAIL mult_all: got %0d/%b want 4/1111", mult, out1);
        end
        tick();
        checks++;
        if (fire !== 4'hF) begin
            errors++;
            $display("FAIL mult_fire: got %b want 1111", fire);
        end
        tick();
        nrst = 1'b0;
        #1;
        checks++;
        if (fire !== 4'h0 || out1 !== 4'h0 || mult !== 3'd0) begin
            errors++;
            $display("FAIL nrst_async: got %b/%b/%0d want 0/0/0",
                     fire, out1, mult);
        end
        tick();
        nrst = 1'b1;
        ticks(3);
        checks++;
        if (fire !== 4'h0) begin
            errors++;
            $display("FAIL nrst_idle: got %b want 0000", fire);
        end
        read_hist(3, 0, v);
        checks++;
        if (v !== 4'd0) begin
            errors++;
            $display("FAIL nrst_hist30: got %0d want 0", v);
        end
        firingticks = 8'd1;
    endtask

    initial begin
        nrst         = 1'b0;
        lvds_rx      = '0;
        phaseoffset  = 2'd0;
        usefullwidth = 1'b0;
        vetopmtlast  = 1'b0;
        passthrough  = 1'b0;
        firingticks  = 8'd1;
        deadticks    = 8'd0;
        resethist    = 1'b0;
        hist_ch      = 2'd0;
        hist_bin     = 2'd0;
        test_reset();
        test_single_bin();
        test_straddle();
        test_veto();
        test_dead_time();
        test_passthrough();
        test_saturate();
        test_mult_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
